data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder_wait_counter.sv | 39 +++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH   = 128;
  localparam int DEFAULT_LATENCY = 2;
  localparam int WORD_BYTES      = 4;
  localparam int CNT_W           = 4;

  // An access is illegal when it is not word aligned or lands past the array.
  function automatic logic addr_error(input logic [31:0] addr, input int depth);
    logic [31:0] idx;
    logic        misaligned;
    idx        = addr / 32'(WORD_BYTES);
    misaligned = (addr % 32'(WORD_BYTES)) != 32'd0;
    addr_error = misaligned || (idx >= 32'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, rdata_o, err_o, busy_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Loadable down-counter that flags the last wait cycle.
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero count also reports done so a stray WAIT entry can never lock up.
  assign done_o = (count_q <= W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed memory that answers each request after a fixed latency.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input logic                 clk_i,
  input logic                 rst_i,
  data_mem_responder_if.slave bus
);
  localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(LATENCY);

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic             accept_s;
  logic             done_s;
  logic             enter_resp_s;
  logic             op_we_s;
  logic [31:0]      op_addr_s;
  logic [31:0]      op_wdata_s;
  logic             op_err_s;
  logic [IDX_W-1:0] op_idx_s;
  logic             ready_s;
  logic             busy_s;

  assign accept_s = (state_q == IDLE) && bus.req_i;

  // With zero latency RESP is entered straight from IDLE, so the live bus
  // values must be used instead of the not-yet-captured copies.
  assign op_we_s    = accept_s ? bus.we_i    : we_q;
  assign op_addr_s  = accept_s ? bus.addr_i  : addr_q;
  assign op_wdata_s = accept_s ? bus.wdata_i : wdata_q;
  assign op_err_s   = addr_error(op_addr_s, DEPTH);
  assign op_idx_s   = op_addr_s[IDX_W+1:2];

  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);

  wait_counter #(.W(CNT_W)) u_wait_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept_s),
    .load_val_i (LAT_V),
    .dec_i      (state_q == WAIT),
    .done_o     (done_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          state_d = (LAT_V == 4'd0) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (done_s) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_q)
      IDLE:    begin ready_s = 1'b0; busy_s = 1'b0; end
      WAIT:    begin ready_s = 1'b0; busy_s = 1'b1; end
      RESP:    begin ready_s = 1'b1; busy_s = 1'b1; end
      default: begin ready_s = 1'b0; busy_s = 1'b0; end
    endcase
  end

  // Capture the request fields at accept; later bus activity is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept_s) begin
      we_q    <= bus.we_i;
      addr_q  <= bus.addr_i;
      wdata_q <= bus.wdata_i;
    end else begin
      we_q    <= we_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // Response data/error are only non-zero for the single RESP cycle.
  always_comb begin
    rdata_d = 32'h0;
    err_d   = 1'b0;
    if (enter_resp_s) begin
      err_d   = op_err_s;
      rdata_d = (!op_we_s && !op_err_s) ? mem_q[op_idx_s] : 32'h0;
    end else begin
      err_d   = 1'b0;
      rdata_d = 32'h0;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory array: cleared by reset, written on the edge entering RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (enter_resp_s && op_we_s && !op_err_s) begin
      mem_q[op_idx_s] <= op_wdata_s;
    end
  end

  assign bus.ready_o = ready_s;
  assign bus.busy_o  = busy_s;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;

endmodule
